// File: rtl/exu_lsu.sv
// exu_lsu: multi-cycle load/store unit with lane-aligned bus requests, byte strobes,
// load extension, misalignment/bus-error faults and a response watchdog.
`default_nettype none

module exu_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_fault,
  output logic [1:0]        out_cause
);

  localparam int SW = XLEN / 8;
  localparam int LB = $clog2(SW);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_ALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUS   = 2'd2;
  localparam logic [1:0] CAUSE_TMO   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [LB-1:0]     lane_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [SW-1:0]     wstrb_q;
  logic [XLEN-1:0]   rdata_q;
  logic [TW-1:0]     cnt_q;
  logic              fault_q;
  logic [1:0]        cause_q;

  logic [LB-1:0]     lane_d;
  logic              misalign_d;
  logic [7:0]        strb_base_d;
  logic [SW-1:0]     wstrb_d;
  logic [XLEN-1:0]   wdata_d;
  logic [XLEN-1:0]   addr_d;
  logic              expire_d;
  logic [XLEN-1:0]   rsh_d;
  logic [XLEN-1:0]   mask_d;
  logic              sign_d;
  logic [XLEN-1:0]   ext_d;

  assign lane_d  = in_addr[LB-1:0];
  assign addr_d  = {in_addr[XLEN-1:LB], LB'(0)};
  assign wdata_d = in_wdata << {lane_d, 3'b000};
  assign wstrb_d = SW'(strb_base_d) << lane_d;

  always_comb begin
    misalign_d  = 1'b0;
    strb_base_d = 8'h01;
    case (in_size)
      2'd0: begin misalign_d = 1'b0;          strb_base_d = 8'h01; end
      2'd1: begin misalign_d = in_addr[0];    strb_base_d = 8'h03; end
      2'd2: begin misalign_d = |in_addr[1:0]; strb_base_d = 8'h0F; end
      default: begin
        // A doubleword has no legal encoding on a 32-bit datapath.
        misalign_d  = (XLEN == 32) | (|in_addr[2:0]);
        strb_base_d = 8'hFF;
      end
    endcase
  end

  assign expire_d = (TIMEOUT != 0) && (cnt_q >= TO_LAST);
  assign rsh_d    = mem_rsp_rdata >> {lane_q, 3'b000};

  always_comb begin
    mask_d = '1;
    sign_d = 1'b0;
    case (size_q)
      2'd0:    begin mask_d = XLEN'(8'hFF);         sign_d = rsh_d[7];  end
      2'd1:    begin mask_d = XLEN'(16'hFFFF);      sign_d = rsh_d[15]; end
      2'd2:    begin mask_d = XLEN'(32'hFFFF_FFFF); sign_d = rsh_d[31]; end
      default: begin mask_d = '1;                   sign_d = 1'b0;      end
    endcase
  end

  // When the field fills XLEN the mask is all ones and the upper fill vanishes.
  assign ext_d = (rsh_d & mask_d) | ((!uns_q && sign_d) ? ~mask_d : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      lane_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            we_q    <= in_we;
            uns_q   <= in_unsigned;
            size_q  <= in_size;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= '0;
            cnt_q   <= '0;
            if (misalign_d) begin
              state_q <= S_DONE;
              fault_q <= 1'b1;
              cause_q <= CAUSE_ALIGN;
            end else begin
              state_q <= S_REQ;
              fault_q <= 1'b0;
              cause_q <= CAUSE_NONE;
            end
          end
        end
        S_REQ: begin
          if (TIMEOUT != 0) cnt_q <= cnt_q + 1'b1;
          if (mem_req_ready) begin
            state_q <= S_RESP;
          end else if (expire_d) begin
            state_q <= S_DONE;
            fault_q <= 1'b1;
            cause_q <= CAUSE_TMO;
          end
        end
        S_RESP: begin
          if (TIMEOUT != 0) cnt_q <= cnt_q + 1'b1;
          // A response arriving in the expiry cycle still completes the op.
          if (mem_rsp_valid) begin
            state_q <= S_DONE;
            if (mem_rsp_err) begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_BUS;
            end else begin
              rdata_q <= we_q ? '0 : ext_d;
            end
          end else if (expire_d) begin
            state_q <= S_DONE;
            fault_q <= 1'b1;
            cause_q <= CAUSE_TMO;
          end
        end
        default: begin
          if (out_ready) state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = mem_req_valid & we_q;
  assign mem_req_addr  = mem_req_valid ? addr_q  : '0;
  assign mem_req_wdata = mem_req_valid ? wdata_q : '0;
  assign mem_req_wstrb = mem_req_valid ? wstrb_q : '0;
  assign out_valid     = (state_q == S_DONE);
  assign out_rdata     = out_valid ? rdata_q : '0;
  assign out_fault     = out_valid & fault_q;
  assign out_cause     = out_valid ? cause_q : CAUSE_NONE;

endmodule

`default_nettype wire
